// File: rtl/mem_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the synchronous memory port.
// The slave modport is the arbiter's view; master is the view of the surrounding system.
interface mem_arbiter_if #(
    parameter int AW = 16,
    parameter int DW = 8
);
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_gnt;
    logic          cpu_rvalid;
    logic [DW-1:0] cpu_rdata;

    logic          dma_req;
    logic          dma_we;
    logic [AW-1:0] dma_addr;
    logic [DW-1:0] dma_wdata;
    logic          dma_gnt;
    logic          dma_rvalid;
    logic [DW-1:0] dma_rdata;

    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    logic          dma_pri;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  dma_req, dma_we, dma_addr, dma_wdata,
        input  mem_rdata,
        output cpu_gnt, cpu_rvalid, cpu_rdata,
        output dma_gnt, dma_rvalid, dma_rdata,
        output mem_addr, mem_we, mem_wdata,
        output dma_pri
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output dma_req, dma_we, dma_addr, dma_wdata,
        output mem_rdata,
        input  cpu_gnt, cpu_rvalid, cpu_rdata,
        input  dma_gnt, dma_rvalid, dma_rdata,
        input  mem_addr, mem_we, mem_wdata,
        input  dma_pri
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: CPU has priority, a wait counter forces a bounded DMA burst
// so the DMA port always makes progress. Read data returns one cycle after grant.
module mem_arbiter #(
    parameter int AW        = 16,
    parameter int DW        = 8,
    parameter int MAX_WAIT  = 3,
    parameter int MAX_BURST = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    mem_arbiter_if.slave   arb_if
);
    typedef enum logic [0:0] {
        CPU_PRI   = 1'b0,
        DMA_BURST = 1'b1
    } state_e;

    localparam logic [3:0] WAIT_LAST  = 4'(MAX_WAIT - 1);
    localparam logic [3:0] WAIT_SAT   = 4'(MAX_WAIT);
    localparam logic [3:0] BURST_LAST = 4'(MAX_BURST - 1);

    state_e        state_q, state_d;
    logic [3:0]    wait_cnt_q, wait_cnt_d;
    logic [3:0]    burst_cnt_q, burst_cnt_d;
    logic          cpu_rvalid_q, dma_rvalid_q, dma_pri_q;

    logic          cpu_gnt, dma_gnt;
    logic [AW-1:0] mem_addr_mux;
    logic [DW-1:0] mem_wdata_mux;

    // Grants are combinational and forced low while reset is held.
    always_comb begin
        cpu_gnt = 1'b0;
        dma_gnt = 1'b0;
        if (rst_n) begin
            case (state_q)
                CPU_PRI: begin
                    cpu_gnt = arb_if.cpu_req;
                    dma_gnt = arb_if.dma_req & ~arb_if.cpu_req;
                end
                DMA_BURST: begin
                    dma_gnt = arb_if.dma_req;
                    cpu_gnt = arb_if.cpu_req & ~arb_if.dma_req;
                end
                default: begin
                    cpu_gnt = 1'b0;
                    dma_gnt = 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        burst_cnt_d = burst_cnt_q;
        case (state_q)
            CPU_PRI: begin
                // Idle-CPU DMA grants here never count toward a burst.
                burst_cnt_d = 4'd0;
                if (arb_if.dma_req && !dma_gnt) begin
                    if (wait_cnt_q >= WAIT_LAST) begin
                        state_d    = DMA_BURST;
                        wait_cnt_d = 4'd0;
                    end else if (wait_cnt_q != WAIT_SAT) begin
                        wait_cnt_d = wait_cnt_q + 4'd1;
                    end
                end else begin
                    wait_cnt_d = 4'd0;
                end
            end
            DMA_BURST: begin
                wait_cnt_d = 4'd0;
                if (!arb_if.dma_req) begin
                    state_d     = CPU_PRI;
                    burst_cnt_d = 4'd0;
                end else if (dma_gnt) begin
                    if (burst_cnt_q >= BURST_LAST) begin
                        state_d     = CPU_PRI;
                        burst_cnt_d = 4'd0;
                    end else begin
                        burst_cnt_d = burst_cnt_q + 4'd1;
                    end
                end
            end
            default: begin
                state_d     = CPU_PRI;
                wait_cnt_d  = 4'd0;
                burst_cnt_d = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= CPU_PRI;
            wait_cnt_q   <= 4'd0;
            burst_cnt_q  <= 4'd0;
            cpu_rvalid_q <= 1'b0;
            dma_rvalid_q <= 1'b0;
            dma_pri_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            wait_cnt_q   <= wait_cnt_d;
            burst_cnt_q  <= burst_cnt_d;
            cpu_rvalid_q <= cpu_gnt & ~arb_if.cpu_we;
            dma_rvalid_q <= dma_gnt & ~arb_if.dma_we;
            // Debug flag lags the state by one cycle.
            dma_pri_q    <= (state_q == DMA_BURST);
        end
    end

    // CPU drives the memory port by default, even with no grant.
    always_comb begin
        mem_addr_mux  = arb_if.cpu_addr;
        mem_wdata_mux = arb_if.cpu_wdata;
        if (dma_gnt) begin
            mem_addr_mux  = arb_if.dma_addr;
            mem_wdata_mux = arb_if.dma_wdata;
        end
    end

    assign arb_if.cpu_gnt    = cpu_gnt;
    assign arb_if.dma_gnt    = dma_gnt;
    assign arb_if.mem_addr   = mem_addr_mux;
    assign arb_if.mem_wdata  = mem_wdata_mux;
    assign arb_if.mem_we     = (cpu_gnt & arb_if.cpu_we) | (dma_gnt & arb_if.dma_we);
    assign arb_if.cpu_rvalid = cpu_rvalid_q;
    assign arb_if.dma_rvalid = dma_rvalid_q;
    assign arb_if.cpu_rdata  = arb_if.mem_rdata;
    assign arb_if.dma_rdata  = arb_if.mem_rdata;
    assign arb_if.dma_pri    = dma_pri_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus a random run, with a read-data
// scoreboard that queues expected data at grant time and pops it on rvalid.
module tb_mem_arbiter;
    localparam int AW        = 16;
    localparam int DW        = 8;
    localparam int MAX_WAIT  = 3;
    localparam int MAX_BURST = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    mem_arbiter #(
        .AW(AW), .DW(DW), .MAX_WAIT(MAX_WAIT), .MAX_BURST(MAX_BURST)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .arb_if (bus.slave)
    );

    // Synchronous memory: read of the presented address appears one cycle later.
    logic [DW-1:0] mem [0:(1<<AW)-1];
    always @(posedge clk) begin
        bus.mem_rdata <= mem[bus.mem_addr];
        if (bus.mem_we === 1'b1) mem[bus.mem_addr] = bus.mem_wdata;
    end

    int n_checks = 0;
    int n_fail   = 0;

    logic [DW-1:0] cpu_exp_q[$];
    logic [DW-1:0] dma_exp_q[$];
    logic          cpu_pend = 1'b0;
    logic          dma_pend = 1'b0;
    logic [DW-1:0] mon_exp;
    int            deny_run = 0;

    // Per-cycle monitor: exclusion, rvalid timing, read data and DMA starvation bound.
    always @(negedge clk) begin
        if (!rst_n) begin
            cpu_exp_q.delete();
            dma_exp_q.delete();
            cpu_pend = 1'b0;
            dma_pend = 1'b0;
            deny_run = 0;
        end else begin
            n_checks++;
            if (bus.cpu_gnt === 1'b1 && bus.dma_gnt === 1'b1) begin
                n_fail++;
                $display("FAIL mutex: cpu_gnt=%b dma_gnt=%b, required not both 1", bus.cpu_gnt, bus.dma_gnt);
            end
            n_checks++;
            if ((bus.cpu_gnt === 1'b1 && !bus.cpu_req) || (bus.dma_gnt === 1'b1 && !bus.dma_req)) begin
                n_fail++;
                $display("FAIL gnt_without_req: gnt cpu=%b dma=%b req cpu=%b dma=%b", bus.cpu_gnt, bus.dma_gnt, bus.cpu_req, bus.dma_req);
            end
            n_checks++;
            if ((bus.cpu_gnt | bus.dma_gnt) !== (bus.cpu_req | bus.dma_req)) begin
                n_fail++;
                $display("FAIL work_conserving: any_gnt=%b, required %b", bus.cpu_gnt | bus.dma_gnt, bus.cpu_req | bus.dma_req);
            end
            n_checks++;
            if (bus.cpu_rvalid !== cpu_pend) begin
                n_fail++;
                $display("FAIL cpu_rvalid: got %b required %b", bus.cpu_rvalid, cpu_pend);
            end
            if (cpu_pend && cpu_exp_q.size() > 0) begin
                mon_exp = cpu_exp_q.pop_front();
                n_checks++;
                if (bus.cpu_rdata !== mon_exp) begin
                    n_fail++;
                    $display("FAIL cpu_rdata: got %02h required %02h", bus.cpu_rdata, mon_exp);
                end
            end
            n_checks++;
            if (bus.dma_rvalid !== dma_pend) begin
                n_fail++;
                $display("FAIL dma_rvalid: got %b required %b", bus.dma_rvalid, dma_pend);
            end
            if (dma_pend && dma_exp_q.size() > 0) begin
                mon_exp = dma_exp_q.pop_front();
                n_checks++;
                if (bus.dma_rdata !== mon_exp) begin
                    n_fail++;
                    $display("FAIL dma_rdata: got %02h required %02h", bus.dma_rdata, mon_exp);
                end
            end
            cpu_pend = (bus.cpu_gnt === 1'b1) && !bus.cpu_we;
            dma_pend = (bus.dma_gnt === 1'b1) && !bus.dma_we;
            if (cpu_pend) cpu_exp_q.push_back(mem[bus.cpu_addr]);
            if (dma_pend) dma_exp_q.push_back(mem[bus.dma_addr]);
            if (bus.dma_req && bus.dma_gnt !== 1'b1) deny_run++;
            else deny_run = 0;
            n_checks++;
            if (deny_run > MAX_WAIT) begin
                n_fail++;
                $display("FAIL starvation: dma denied %0d cycles, limit %0d", deny_run, MAX_WAIT);
            end
        end
    end

    task automatic drive_idle(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk); #1;
            bus.cpu_req = 1'b0;
            bus.dma_req = 1'b0;
        end
    endtask

    task automatic test_reset();
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 16'h0010; bus.cpu_wdata = 8'h11;
        bus.dma_req = 1'b1; bus.dma_we = 1'b1; bus.dma_addr = 16'h0020; bus.dma_wdata = 8'h22;
        #12;
        n_checks++;
        if (bus.cpu_gnt !== 1'b0 || bus.dma_gnt !== 1'b0 || bus.mem_we !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_gnt: cpu_gnt=%b dma_gnt=%b mem_we=%b, required 0", bus.cpu_gnt, bus.dma_gnt, bus.mem_we);
        end
        n_checks++;
        if (bus.cpu_rvalid !== 1'b0 || bus.dma_rvalid !== 1'b0 || bus.dma_pri !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_regs: cpu_rvalid=%b dma_rvalid=%b dma_pri=%b, required 0", bus.cpu_rvalid, bus.dma_rvalid, bus.dma_pri);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (bus.cpu_gnt !== 1'b1 || bus.dma_gnt !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_first_owner: cpu_gnt=%b dma_gnt=%b, required 1/0", bus.cpu_gnt, bus.dma_gnt);
        end
        drive_idle(2);
        $display("test_reset done");
    endtask

    task automatic test_cpu_only();
        logic [AW-1:0] a;
        logic [DW-1:0] exp_last;
        for (int i = 0; i < 4; i++) begin
            a = 16'h0200 + 16'(i);
            @(posedge clk); #1;
            bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = a;
            bus.dma_req = 1'b0;
            @(negedge clk);
            n_checks++;
            if (bus.cpu_gnt !== 1'b1 || bus.dma_gnt !== 1'b0) begin
                n_fail++;
                $display("FAIL cpu_only_gnt[%0d]: cpu_gnt=%b dma_gnt=%b, required 1/0", i, bus.cpu_gnt, bus.dma_gnt);
            end
            n_checks++;
            if (bus.mem_addr !== a) begin
                n_fail++;
                $display("FAIL cpu_only_addr[%0d]: got %04h required %04h", i, bus.mem_addr, a);
            end
            $display("cpu read addr=%04h gnt=%b", a, bus.cpu_gnt);
        end
        exp_last = mem[16'h0203];
        @(posedge clk); #1;
        bus.cpu_req = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus.cpu_rvalid !== 1'b1 || bus.cpu_rdata !== exp_last) begin
            n_fail++;
            $display("FAIL cpu_only_last_read: rvalid=%b rdata=%02h, required 1/%02h", bus.cpu_rvalid, bus.cpu_rdata, exp_last);
        end
        drive_idle(1);
    endtask

    task automatic test_dma_write();
        @(posedge clk); #1;
        bus.cpu_req = 1'b0;
        bus.dma_req = 1'b1; bus.dma_we = 1'b1; bus.dma_addr = 16'h1000; bus.dma_wdata = 8'hA5;
        @(negedge clk);
        n_checks++;
        if (bus.dma_gnt !== 1'b1 || bus.cpu_gnt !== 1'b0 || bus.mem_we !== 1'b1) begin
            n_fail++;
            $display("FAIL dma_write_gnt: dma_gnt=%b cpu_gnt=%b mem_we=%b, required 1/0/1", bus.dma_gnt, bus.cpu_gnt, bus.mem_we);
        end
        n_checks++;
        if (bus.mem_addr !== 16'h1000 || bus.mem_wdata !== 8'hA5) begin
            n_fail++;
            $display("FAIL dma_write_bus: addr=%04h data=%02h, required 1000/a5", bus.mem_addr, bus.mem_wdata);
        end
        n_checks++;
        if (bus.dma_pri !== 1'b0) begin
            n_fail++;
            $display("FAIL dma_write_pri: got %b required 0", bus.dma_pri);
        end
        $display("dma write addr=1000 data=a5 gnt=%b", bus.dma_gnt);
        @(posedge clk); #1;
        bus.dma_req = 1'b0;
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h1000;
        @(negedge clk);
        n_checks++;
        if (bus.dma_rvalid !== 1'b0 || bus.dma_pri !== 1'b0) begin
            n_fail++;
            $display("FAIL dma_write_after: dma_rvalid=%b dma_pri=%b, required 0/0", bus.dma_rvalid, bus.dma_pri);
        end
        @(posedge clk); #1;
        bus.cpu_req = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus.cpu_rvalid !== 1'b1 || bus.cpu_rdata !== 8'hA5) begin
            n_fail++;
            $display("FAIL dma_write_readback: rvalid=%b rdata=%02h, required 1/a5", bus.cpu_rvalid, bus.cpu_rdata);
        end
        drive_idle(1);
    endtask

    task automatic test_starvation();
        logic exp_dma, exp_pri;
        for (int c = 0; c < 14; c++) begin
            @(posedge clk); #1;
            bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h0300;
            bus.dma_req = 1'b1; bus.dma_we = 1'b0; bus.dma_addr = 16'h0400;
            @(negedge clk);
            exp_dma = (c >= 3 && c <= 6) || (c >= 10 && c <= 13);
            exp_pri = (c >= 4 && c <= 7) || (c >= 11);
            n_checks++;
            if (bus.cpu_gnt !== !exp_dma || bus.dma_gnt !== exp_dma) begin
                n_fail++;
                $display("FAIL starve_gnt[%0d]: cpu_gnt=%b dma_gnt=%b, required %b/%b", c, bus.cpu_gnt, bus.dma_gnt, !exp_dma, exp_dma);
            end
            n_checks++;
            if (bus.dma_pri !== exp_pri) begin
                n_fail++;
                $display("FAIL starve_pri[%0d]: got %b required %b", c, bus.dma_pri, exp_pri);
            end
            $display("starve cycle %0d cpu_gnt=%b dma_gnt=%b dma_pri=%b", c, bus.cpu_gnt, bus.dma_gnt, bus.dma_pri);
        end
        drive_idle(2);
    endtask

    task automatic test_burst_abandon();
        logic exp_dma, exp_pri;
        for (int c = 0; c < 11; c++) begin
            @(posedge clk); #1;
            bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h0500;
            bus.dma_req = (c != 5); bus.dma_we = 1'b0; bus.dma_addr = 16'h0600;
            @(negedge clk);
            exp_dma = (c == 3) || (c == 4) || (c == 9) || (c == 10);
            exp_pri = (c >= 4 && c <= 6) || (c == 10);
            n_checks++;
            if (bus.cpu_gnt !== !exp_dma || bus.dma_gnt !== exp_dma) begin
                n_fail++;
                $display("FAIL abandon_gnt[%0d]: cpu_gnt=%b dma_gnt=%b, required %b/%b", c, bus.cpu_gnt, bus.dma_gnt, !exp_dma, exp_dma);
            end
            n_checks++;
            if (bus.dma_pri !== exp_pri) begin
                n_fail++;
                $display("FAIL abandon_pri[%0d]: got %b required %b", c, bus.dma_pri, exp_pri);
            end
            $display("abandon cycle %0d dma_req=%b cpu_gnt=%b dma_gnt=%b", c, bus.dma_req, bus.cpu_gnt, bus.dma_gnt);
        end
        drive_idle(2);
    endtask

    task automatic test_async_reset();
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 16'h0700; bus.cpu_wdata = 8'h77;
            bus.dma_req = 1'b1; bus.dma_we = 1'b0; bus.dma_addr = 16'h0800;
        end
        @(posedge clk); #3;
        n_checks++;
        if (bus.dma_gnt !== 1'b1 || bus.dma_rvalid !== 1'b1 || bus.dma_pri !== 1'b1) begin
            n_fail++;
            $display("FAIL areset_setup: dma_gnt=%b dma_rvalid=%b dma_pri=%b, required 1/1/1", bus.dma_gnt, bus.dma_rvalid, bus.dma_pri);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (bus.cpu_gnt !== 1'b0 || bus.dma_gnt !== 1'b0 || bus.mem_we !== 1'b0) begin
            n_fail++;
            $display("FAIL areset_gnt: cpu_gnt=%b dma_gnt=%b mem_we=%b, required 0", bus.cpu_gnt, bus.dma_gnt, bus.mem_we);
        end
        n_checks++;
        if (bus.cpu_rvalid !== 1'b0 || bus.dma_rvalid !== 1'b0 || bus.dma_pri !== 1'b0) begin
            n_fail++;
            $display("FAIL areset_regs: cpu_rvalid=%b dma_rvalid=%b dma_pri=%b, required 0", bus.cpu_rvalid, bus.dma_rvalid, bus.dma_pri);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (bus.cpu_gnt !== 1'b1 || bus.dma_gnt !== 1'b0) begin
            n_fail++;
            $display("FAIL areset_first_owner: cpu_gnt=%b dma_gnt=%b, required 1/0", bus.cpu_gnt, bus.dma_gnt);
        end
        $display("async reset released, cpu_gnt=%b", bus.cpu_gnt);
        drive_idle(2);
    endtask

    task automatic test_random();
        logic cpu_done = 1'b1;
        logic dma_done = 1'b1;
        int   dma_grants = 0;
        int   cpu_grants = 0;
        for (int c = 0; c < 10000; c++) begin
            @(posedge clk); #1;
            if (cpu_done) begin
                bus.cpu_req   = ($urandom_range(0, 9) < 6);
                bus.cpu_we    = 1'($urandom_range(0, 1));
                bus.cpu_addr  = 16'($urandom_range(0, 63));
                bus.cpu_wdata = 8'($urandom);
            end
            if (dma_done) begin
                bus.dma_req   = ($urandom_range(0, 9) < 6);
                bus.dma_we    = 1'($urandom_range(0, 1));
                bus.dma_addr  = 16'($urandom_range(0, 63));
                bus.dma_wdata = 8'($urandom);
            end
            @(negedge clk);
            cpu_done = !bus.cpu_req || (bus.cpu_gnt === 1'b1);
            dma_done = !bus.dma_req || (bus.dma_gnt === 1'b1);
            if (bus.cpu_gnt === 1'b1) cpu_grants++;
            if (bus.dma_gnt === 1'b1) dma_grants++;
        end
        n_checks++;
        if (dma_grants == 0 || cpu_grants == 0) begin
            n_fail++;
            $display("FAIL random_progress: cpu_grants=%0d dma_grants=%0d, required both nonzero", cpu_grants, dma_grants);
        end
        $display("random run: cpu_grants=%0d dma_grants=%0d", cpu_grants, dma_grants);
        drive_idle(2);
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = 8'(i ^ (i >> 8));
        bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
        bus.dma_req = 1'b0; bus.dma_we = 1'b0; bus.dma_addr = '0; bus.dma_wdata = '0;
        test_reset();
        test_cpu_only();
        test_dma_write();
        test_starvation();
        test_burst_abandon();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
